// File: rtl/mem_responder.sv
// Memory-side responder: latches a MemRead/MemWrite request, waits LATENCY edges,
// performs the word access and pulses ready; bad requests complete with a sticky err.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_r;
  logic              wr_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r;
  logic              busy_r;
  logic              err_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              req_s;
  logic              accept_s;
  logic              access_s;
  logic              fault_s;
  logic              do_wr_s;
  logic              do_rd_s;
  logic [IDX_W-1:0]  idx_s;

  // A request is bad if it asks for both operations, is misaligned, or lies past the array.
  function automatic logic req_fault(input logic rd, input logic wr, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] word;
    word = a[ADDR_W-1:2];
    return (rd & wr) | (a[1:0] != 2'b00) | (word >= (ADDR_W-2)'(DEPTH));
  endfunction

  assign req_s = mem_read | mem_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; cnt_r holds the WAIT edges still to go, so DONE lands LATENCY edges after acceptance
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) next_state_s = WAIT;
        else       next_state_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == 4'd0) next_state_s = DONE;
        else               next_state_s = WAIT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM-decoded strobes for the datapath
  always_comb begin
    accept_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = req_s;
      WAIT:    access_s = (cnt_r == 4'd0);
      DONE:    access_s = 1'b0;
      default: access_s = 1'b0;
    endcase
    fault_s = req_fault(rd_r, wr_r, addr_r);
    idx_s   = addr_r[IDX_W+1:2];
    do_wr_s = access_s & wr_r & ~fault_s;
    do_rd_s = access_s & rd_r;
  end

  // Request latch, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 4'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= access_s;
      busy_r  <= (next_state_s != IDLE);
      if (accept_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        rd_r    <= mem_read;
        wr_r    <= mem_write;
        cnt_r   <= 4'(LATENCY - 1);
      end else if (state_r == WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (do_rd_s) begin
        rdata_r <= fault_s ? {DATA_W{1'b0}} : mem_r[idx_s];
      end
      if (access_s & fault_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Storage array survives reset; a reset on the access edge blocks the commit
  always_ff @(posedge clk) begin
    if (!rst && do_wr_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign busy  = busy_r;
  assign err   = err_r;

endmodule
